// File: rtl/ram_bus_arbiter_pkg.sv
// Shared types and helpers for the RAM bus arbiter: FSM encoding, default widths,
// and the per-requester slice extractor for packed address/data buses.
package arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } arb_state_t;

  localparam int unsigned DEF_ADDR_W = 8;
  localparam int unsigned DEF_DATA_W = 8;

  // Packed buses wider than BUS_W or slices wider than SLICE_W are not supported.
  localparam int unsigned BUS_W   = 64;
  localparam int unsigned SLICE_W = 32;

  function automatic logic [SLICE_W-1:0] req_slice(input logic [BUS_W-1:0] bus,
                                                   input int unsigned idx,
                                                   input int unsigned w);
    logic [BUS_W-1:0] shifted;
    logic [BUS_W-1:0] mask;
    shifted = bus >> (idx * w);
    mask    = (BUS_W'(1) << w) - BUS_W'(1);
    return SLICE_W'(shifted & mask);
  endfunction

endpackage

// File: rtl/ram_bus_arbiter_if.sv
// Requester-side bus of the RAM arbiter: requests and write payloads in,
// one-hot grant/ack and read data out.
interface ram_bus_arbiter_if #(
  parameter int unsigned N_REQ  = 3,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
);
  logic [N_REQ-1:0]        req;
  logic [N_REQ-1:0]        we;
  logic [N_REQ*ADDR_W-1:0] addr;
  logic [N_REQ*DATA_W-1:0] wdata;
  logic                    cpu_lock;
  logic [N_REQ-1:0]        gnt;
  logic [N_REQ-1:0]        ack;
  logic [DATA_W-1:0]       rdata;

  modport master (output req, we, addr, wdata, cpu_lock, input gnt, ack, rdata);
  modport slave  (input req, we, addr, wdata, cpu_lock, output gnt, ack, rdata);
endinterface

// File: rtl/ram_bus_arbiter_rr_pick.sv
// Combinational rotating-priority selector: first requester with req set,
// searching upward from rr_ptr modulo N_REQ.
module rr_pick #(
  parameter int unsigned N_REQ = 3,
  parameter int unsigned PTR_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] rr_ptr,
  output logic [PTR_W-1:0] winner,
  output logic             valid
);
  always_comb begin
    int unsigned idx;
    idx    = 0;
    winner = '0;
    valid  = 1'b0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = 32'(rr_ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!valid && req[idx]) begin
        valid  = 1'b1;
        winner = PTR_W'(idx);
      end
    end
  end
endmodule

// File: rtl/ram_bus_arbiter.sv
// Single-port RAM arbiter for CPU, loader and display scanner: rotating priority,
// fixed GRANT/ACCESS/RESP sequence, and a bounded CPU bus lock.
module ram_bus_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned N_REQ    = 3,
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned LOCK_MAX = 4
) (
  input  logic              dclk,
  input  logic              reset,
  ram_bus_arbiter_if.slave  bif,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_en,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy,
  output logic              lock_brk
);
  localparam int unsigned PTR_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned LCNT_W = (LOCK_MAX > 2) ? $clog2(LOCK_MAX) : 1;

  arb_state_t        state_q, state_d;
  logic [PTR_W-1:0]  owner_q, owner_d;
  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [LCNT_W-1:0] lock_cnt_q, lock_cnt_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic              ram_we_q, ram_we_d;
  logic              ram_en_q, ram_en_d;
  logic              ram_wr_q, ram_wr_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic [N_REQ-1:0]  ack_q, ack_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              lock_brk_q, lock_brk_d;

  logic [PTR_W-1:0]  pick_idx;
  logic              pick_vld;
  logic              lock_hold;

  rr_pick #(.N_REQ(N_REQ), .PTR_W(PTR_W)) u_pick (
    .req    (bif.req),
    .rr_ptr (rr_ptr_q),
    .winner (pick_idx),
    .valid  (pick_vld)
  );

  assign lock_hold = (owner_q == '0) && bif.cpu_lock && bif.req[0];

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    lock_cnt_d  = lock_cnt_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    ram_we_d    = ram_we_q;
    gnt_d       = gnt_q;
    rdata_d     = rdata_q;
    ram_en_d    = 1'b0;
    ram_wr_d    = 1'b0;
    ack_d       = '0;
    lock_brk_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          owner_d     = pick_idx;
          ram_addr_d  = ADDR_W'(req_slice(BUS_W'(bif.addr), 32'(pick_idx), ADDR_W));
          ram_wdata_d = DATA_W'(req_slice(BUS_W'(bif.wdata), 32'(pick_idx), DATA_W));
          ram_we_d    = bif.we[pick_idx];
          gnt_d       = N_REQ'(1) << pick_idx;
          state_d     = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (!bif.req[owner_q]) begin
          gnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          ram_en_d = 1'b1;
          ram_wr_d = ram_we_q;
          state_d  = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        ack_d   = gnt_q;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (!ram_we_q) rdata_d = ram_rdata;
        if (lock_hold && (lock_cnt_q < LCNT_W'(LOCK_MAX - 1))) begin
          // Locked CPU skips IDLE and re-arbitration; gnt stays on requester 0.
          lock_cnt_d  = lock_cnt_q + LCNT_W'(1);
          ram_addr_d  = bif.addr[ADDR_W-1:0];
          ram_wdata_d = bif.wdata[DATA_W-1:0];
          ram_we_d    = bif.we[0];
          state_d     = ST_GRANT;
        end else begin
          if (lock_hold) begin
            lock_brk_d = 1'b1;
            rr_ptr_d   = PTR_W'(1);
          end else begin
            rr_ptr_d = (32'(owner_q) == N_REQ - 1) ? '0 : owner_q + PTR_W'(1);
          end
          lock_cnt_d = '0;
          gnt_d      = '0;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge dclk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      lock_cnt_q  <= '0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      ram_we_q    <= 1'b0;
      ram_en_q    <= 1'b0;
      ram_wr_q    <= 1'b0;
      gnt_q       <= '0;
      ack_q       <= '0;
      rdata_q     <= '0;
      lock_brk_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      lock_cnt_q  <= lock_cnt_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      ram_we_q    <= ram_we_d;
      ram_en_q    <= ram_en_d;
      ram_wr_q    <= ram_wr_d;
      gnt_q       <= gnt_d;
      ack_q       <= ack_d;
      rdata_q     <= rdata_d;
      lock_brk_q  <= lock_brk_d;
    end
  end

  // Read data bypasses the register during a read RESP so the owner sees it with ack.
  assign bif.rdata = (state_q == ST_RESP && !ram_we_q) ? ram_rdata : rdata_q;
  assign bif.gnt   = gnt_q;
  assign bif.ack   = ack_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign ram_en    = ram_en_q;
  assign ram_we    = ram_wr_q;
  assign busy      = (state_q != ST_IDLE);
  assign lock_brk  = lock_brk_q;
endmodule

// File: tb/tb_ram_bus_arbiter.sv
// Directed self-checking bench for ram_bus_arbiter with a behavioural synchronous RAM.
module tb_ram_bus_arbiter;
  logic       dclk;
  logic       reset;
  logic [7:0] ram_addr, ram_wdata, ram_rdata;
  logic       ram_en, ram_we, busy, lock_brk;
  logic [7:0] mem [256];
  int unsigned n_cmp, n_fail;

  ram_bus_arbiter_if #(.N_REQ(3), .ADDR_W(8), .DATA_W(8)) bif ();

  ram_bus_arbiter #(.N_REQ(3), .ADDR_W(8), .DATA_W(8), .LOCK_MAX(4)) dut (
    .dclk      (dclk),
    .reset     (reset),
    .bif       (bif),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .ram_rdata (ram_rdata),
    .busy      (busy),
    .lock_brk  (lock_brk)
  );

  initial dclk = 1'b0;
  always #5 dclk = ~dclk;

  // RAM contents after reset: mem[a] = a ^ 0x99 (so mem[0x3C] = 0xA5).
  always @(posedge dclk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'h99;
      ram_rdata <= 8'h00;
    end else if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata     <= mem[ram_addr];
    end
  end

  task automatic step();
    @(posedge dclk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bif.req = '0; bif.we = '0; bif.addr = '0; bif.wdata = '0; bif.cpu_lock = 1'b0;
    step(); step();
    n_cmp++;
    if ({bif.gnt, bif.ack, ram_en, ram_we, busy, lock_brk} !== 10'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 0", {bif.gnt, bif.ack, ram_en, ram_we, busy, lock_brk});
    end
    n_cmp++;
    if ({ram_addr, ram_wdata, bif.rdata} !== 24'h0) begin
      n_fail++; $display("FAIL reset_data: got %h want 0", {ram_addr, ram_wdata, bif.rdata});
    end
    @(negedge dclk);
    reset = 1'b1;
  endtask

  task automatic test_tie();
    logic [7:0] exp_rd;
    bif.req = 3'b111;
    bif.addr = {8'h02, 8'h01, 8'h00};
    for (int n = 0; n < 4; n++) begin
      step();
      n_cmp++;
      if (bif.gnt !== (3'b001 << (n % 3))) begin
        n_fail++; $display("FAIL tie_gnt%0d: got %b want %b", n, bif.gnt, 3'b001 << (n % 3));
      end
      step(); step();
      exp_rd = 8'(n % 3) ^ 8'h99;
      n_cmp++;
      if ({bif.ack, bif.rdata} !== {3'b001 << (n % 3), exp_rd}) begin
        n_fail++; $display("FAIL tie_ack%0d: got %b/%h want %b/%h", n, bif.ack, bif.rdata, 3'b001 << (n % 3), exp_rd);
      end
      if (n == 3) bif.req = '0;
      step();
    end
    n_cmp++;
    if ({busy, bif.gnt, lock_brk} !== 5'b0) begin
      n_fail++; $display("FAIL tie_idle: got %b want 0", {busy, bif.gnt, lock_brk});
    end
  endtask

  task automatic test_single_read();
    bif.req = 3'b100; bif.we = 3'b000; bif.addr[16 +: 8] = 8'h3C;
    step();
    n_cmp++;
    if ({bif.gnt, busy, ram_en} !== 5'b100_1_0) begin
      n_fail++; $display("FAIL rd_grant: got %b want 10010", {bif.gnt, busy, ram_en});
    end
    step();
    n_cmp++;
    if ({ram_en, ram_we, ram_addr} !== {2'b10, 8'h3C}) begin
      n_fail++; $display("FAIL rd_access: got %b/%b/%h want 1/0/3c", ram_en, ram_we, ram_addr);
    end
    step();
    n_cmp++;
    if ({bif.ack, bif.rdata} !== {3'b100, 8'hA5}) begin
      n_fail++; $display("FAIL rd_resp: got %b/%h want 100/a5", bif.ack, bif.rdata);
    end
    bif.req = '0;
    step();
    n_cmp++;
    if ({bif.ack, bif.gnt, busy, bif.rdata} !== {7'b0, 8'hA5}) begin
      n_fail++; $display("FAIL rd_hold: got %b/%b/%b/%h want 0/0/0/a5", bif.ack, bif.gnt, busy, bif.rdata);
    end
  endtask

  task automatic test_abort();
    bif.req = 3'b010; bif.addr[8 +: 8] = 8'h20;
    step();
    n_cmp++;
    if (bif.gnt !== 3'b010) begin
      n_fail++; $display("FAIL ab_grant: got %b want 010", bif.gnt);
    end
    bif.req = '0;
    step();
    n_cmp++;
    if ({bif.gnt, ram_en, busy} !== 5'b0) begin
      n_fail++; $display("FAIL ab_idle: got %b want 0", {bif.gnt, ram_en, busy});
    end
    step();
    n_cmp++;
    if ({ram_en, bif.ack} !== 4'b0) begin
      n_fail++; $display("FAIL ab_noacc: got %b want 0", {ram_en, bif.ack});
    end
    // Pointer still at 0 after the abort, so requester 1 beats requester 2.
    bif.req = 3'b110;
    step();
    n_cmp++;
    if (bif.gnt !== 3'b010) begin
      n_fail++; $display("FAIL ab_rrptr: got %b want 010", bif.gnt);
    end
    bif.req = '0;
    step(); step();
  endtask

  task automatic test_write_read();
    bif.req = 3'b010; bif.we = 3'b010; bif.addr[8 +: 8] = 8'h10; bif.wdata[8 +: 8] = 8'h5A;
    step();
    n_cmp++;
    if ({bif.gnt, ram_en, ram_we} !== 5'b010_0_0) begin
      n_fail++; $display("FAIL wr_grant: got %b want 01000", {bif.gnt, ram_en, ram_we});
    end
    step();
    n_cmp++;
    if ({ram_en, ram_we, ram_addr, ram_wdata} !== {2'b11, 8'h10, 8'h5A}) begin
      n_fail++; $display("FAIL wr_access: got %b/%b/%h/%h want 1/1/10/5a", ram_en, ram_we, ram_addr, ram_wdata);
    end
    step();
    n_cmp++;
    if ({bif.ack, ram_we, bif.rdata} !== {3'b010, 1'b0, 8'hA5}) begin
      n_fail++; $display("FAIL wr_resp: got %b/%b/%h want 010/0/a5", bif.ack, ram_we, bif.rdata);
    end
    bif.req = '0; bif.we = '0;
    step();
    bif.req = 3'b010;
    step(); step();
    n_cmp++;
    if ({ram_en, ram_we, ram_addr} !== {2'b10, 8'h10}) begin
      n_fail++; $display("FAIL wr_rdacc: got %b/%b/%h want 1/0/10", ram_en, ram_we, ram_addr);
    end
    step();
    n_cmp++;
    if ({bif.ack, bif.rdata} !== {3'b010, 8'h5A}) begin
      n_fail++; $display("FAIL wr_readback: got %b/%h want 010/5a", bif.ack, bif.rdata);
    end
    bif.req = '0;
    step();
  endtask

  task automatic test_lock();
    bif.req = 3'b011; bif.we = '0; bif.cpu_lock = 1'b1;
    bif.addr[0 +: 8] = 8'h3C; bif.addr[8 +: 8] = 8'h10;
    step();
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if ({bif.gnt, bif.ack} !== 6'b001_000) begin
        n_fail++; $display("FAIL lk_grant%0d: got %b/%b want 001/000", k, bif.gnt, bif.ack);
      end
      step();
      n_cmp++;
      if ({ram_en, ram_addr} !== {1'b1, 8'h3C}) begin
        n_fail++; $display("FAIL lk_access%0d: got %b/%h want 1/3c", k, ram_en, ram_addr);
      end
      step();
      n_cmp++;
      if ({bif.ack, bif.rdata, lock_brk} !== {3'b001, 8'hA5, 1'b0}) begin
        n_fail++; $display("FAIL lk_ack%0d: got %b/%h/%b want 001/a5/0", k, bif.ack, bif.rdata, lock_brk);
      end
      step();
    end
    n_cmp++;
    if ({lock_brk, busy, bif.gnt} !== 5'b1_0_000) begin
      n_fail++; $display("FAIL lk_break: got %b/%b/%b want 1/0/000", lock_brk, busy, bif.gnt);
    end
    step();
    n_cmp++;
    if ({bif.gnt, lock_brk} !== 4'b010_0) begin
      n_fail++; $display("FAIL lk_next: got %b/%b want 010/0", bif.gnt, lock_brk);
    end
    bif.req = 3'b010; bif.cpu_lock = 1'b0;
    step(); step();
    n_cmp++;
    if ({bif.ack, bif.rdata} !== {3'b010, 8'h5A}) begin
      n_fail++; $display("FAIL lk_req1: got %b/%h want 010/5a", bif.ack, bif.rdata);
    end
    bif.req = '0;
    step();
  endtask

  task automatic test_reset_mid();
    bif.req = 3'b100; bif.we = '0; bif.addr[16 +: 8] = 8'h3C;
    step(); step();
    n_cmp++;
    if ({ram_en, busy} !== 2'b11) begin
      n_fail++; $display("FAIL rm_pre: got %b want 11", {ram_en, busy});
    end
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({bif.gnt, ram_en, busy, bif.ack} !== 8'b0) begin
      n_fail++; $display("FAIL rm_async: got %b want 0", {bif.gnt, ram_en, busy, bif.ack});
    end
    bif.req = 3'b111;
    @(negedge dclk);
    reset = 1'b1;
    n_cmp++;
    if ({busy, bif.rdata} !== 9'b0) begin
      n_fail++; $display("FAIL rm_post: got %b/%h want 0/00", busy, bif.rdata);
    end
    step();
    n_cmp++;
    if (bif.gnt !== 3'b001) begin
      n_fail++; $display("FAIL rm_tie: got %b want 001", bif.gnt);
    end
    bif.req = '0;
    step(); step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_cmp = 0;
    n_fail = 0;
    test_reset();
    test_tie();
    test_single_read();
    test_abort();
    test_write_read();
    test_lock();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/ram_bus_arbiter.md
Name: ram_bus_arbiter

Overview:
- Shares the single-port program/data RAM among three requesters.
  - Requester 0: CPU control unit (fetch/LD/ST).
  - Requester 1: program loader.
  - Requester 2: display refresh scanner.
- Sits between the requesters and the RAM macro.
- Sequences each access through a fixed grant/access/response FSM.
- Selects among pending requesters by rotating priority. The CPU may lock the bus for back-to-back accesses; a lock limit bounds how long it can hold it.

Parameters:
- N_REQ, 3, number of requesters (index 0 is the lock-capable CPU).
- ADDR_W, 8, RAM address width.
- DATA_W, 8, RAM data width.
- LOCK_MAX, 4, max consecutive locked transactions before forced release.

Ports:
- dclk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  N_REQ  per-requester access request, level, held until ack.
- we  in  N_REQ  per-requester write enable, sampled with req.
- addr  in  N_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W].
- wdata  in  N_REQ*DATA_W  packed write data, same packing.
- cpu_lock  in  1  requester 0 asks to keep the bus after its current access.
- gnt  out  N_REQ  one-hot owner indication, GRANT through RESP.
- ack  out  N_REQ  one-cycle completion pulse to the owner.
- rdata  out  DATA_W  read data returned to the owner.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_en  out  1  RAM enable (one cycle per access).
- ram_we  out  1  RAM write strobe (qualifies ram_en).
- ram_rdata  in  DATA_W  RAM read data, synchronous: valid the cycle after ram_en.
- busy  out  1  FSM not in IDLE.
- lock_brk  out  1  one-cycle pulse when a lock is forcibly broken.

Behaviour:
- Reset values (async on reset low):
  - state=IDLE; gnt, ack, ram_en, ram_we, busy, lock_brk = 0.
  - ram_addr, ram_wdata, rdata = 0; rr_ptr=0; lock_cnt=0; owner=0.
- IDLE:
  - If any req is set, pick the first requester with req set, searching from rr_ptr upward modulo N_REQ.
  - Register owner, and its addr/we/wdata into ram_addr/ram_we_q/ram_wdata. Go to GRANT.
  - Otherwise stay in IDLE.
- GRANT (1 cycle):
  - gnt[owner]=1.
  - If req[owner] has dropped: abort to IDLE, no RAM access, no ack, rr_ptr unchanged.
  - Otherwise go to ACCESS.
- ACCESS (1 cycle):
  - ram_en=1, ram_we=ram_we_q. Abort is no longer possible. Go to RESP.
- RESP (1 cycle):
  - ack[owner]=1.
  - For reads, rdata = ram_rdata combinationally; the value is captured into the rdata register at the end of RESP and held until the next read RESP.
  - For writes, rdata holds its previous value.
- Latency: req seen in IDLE at cycle T gives gnt from T+1, ram_en at T+2, ack at T+3. Minimum 4 cycles per transaction.
- Leaving RESP, lock check first:
  - If owner==0, cpu_lock=1, req[0]=1 and lock_cnt<LOCK_MAX-1: lock_cnt++, re-latch requester 0 addr/we/wdata, go to GRANT. This gives back-to-back accesses every 3 cycles.
  - If the same conditions hold but lock_cnt==LOCK_MAX-1: pulse lock_brk, lock_cnt=0, rr_ptr=1, go to IDLE.
  - Otherwise: lock_cnt=0, rr_ptr=(owner+1) mod N_REQ, go to IDLE.
- cpu_lock is ignored whenever the owner is not 0.
- Requester interface: addr/we/wdata must be stable from req assertion until ack. A new req may be raised the cycle after ack.
- Simultaneous requests in IDLE: rotating priority from rr_ptr. After reset, requester 0 wins a tie.
- Reset mid-transaction drops gnt/ram_en/ack immediately; in-flight accesses are not completed.
- gnt stays one-hot or zero; busy = (state!=IDLE).

Decomposition:
- Shared package arb_pkg holds:
  - the FSM state encoding ST_IDLE/ST_GRANT/ST_ACCESS/ST_RESP (2-bit);
  - default ADDR_W/DATA_W constants;
  - the unpacking helper for per-requester address and data slices.
- One natural sub-module, rr_pick: combinational rotating-priority selector over N_REQ, taking req and rr_ptr and producing the winner index and a valid flag.

Test Plan:
- Single read: req[2]=1, addr2=0x3C, RAM[0x3C]=0xA5 -> gnt[2]=1 at T+1, ram_en at T+2 with ram_addr=0x3C and ram_we=0, ack[2] at T+3 with rdata=0xA5.
- Write then read: requester 1 writes 0x5A to 0x10, then reads 0x10 -> ram_we=1 only in the write ACCESS cycle; the read returns 0x5A.
- Tie from reset: req=3'b111 held -> grants in order 0,1,2,0; each ack 4 cycles apart.
- CPU lock: req[0]=1, cpu_lock=1, req[1]=1, LOCK_MAX=4 -> four requester-0 acks 3 cycles apart; lock_brk pulses after the 4th; the next grant goes to requester 1.
- Abort: req[1] drops during GRANT -> no ram_en, no ack; FSM returns to IDLE; rr_ptr unchanged.
- Async reset asserted during ACCESS -> gnt, ram_en, busy = 0 in the same cycle; after release, state is IDLE, rdata=0, and requester 0 wins a tie.
